// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small FIFO of {instn, pc, nextpc} between fetch and decode.
// Ready/valid are derived from the registered count only, with no combinational path from in_* to out_*.
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_instn,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_nextpc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instn,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_nextpc,
    input  logic             out_ready,
    output logic [3:0]       count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] instn;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] nextpc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             push, pop;
    entry_t           head;

    assign in_ready  = (count_q != 4'(DEPTH));
    assign out_valid = (count_q != 4'd0);
    assign count     = count_q;

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{instn: in_instn, pc: in_pc, nextpc: in_nextpc};
        end
    end

    // Empty buffer presents zeros so decode sees a NOP.
    always_comb begin
        head = '0;
        if (out_valid) head = mem_q[rd_ptr_q];
    end

    assign out_instn  = head.instn;
    assign out_pc     = head.pc;
    assign out_nextpc = head.nextpc;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=2, WIDTH=32).
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instn, in_pc, in_nextpc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instn, out_pc, out_nextpc;
    logic        out_ready;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    if_id_buffer #(.DEPTH(2), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_instn(in_instn), .in_pc(in_pc), .in_nextpc(in_nextpc),
        .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_instn(out_instn), .out_pc(out_pc), .out_nextpc(out_nextpc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid  = v;
        in_pc     = pc;
        in_nextpc = pc + 32'd4;
        in_instn  = 32'hA000_0000 | pc;
    endtask

    int exp_idx;

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_instn", out_instn,      32'd0);
        chk("rst_out_pc",    out_pc,         32'd0);
        reset = 1'b1;
        step();

        // First push with decode stalled
        in_valid = 1'b1; in_instn = 32'h2008_0005; in_pc = 32'd0; in_nextpc = 32'd4;
        step();
        chk("p1_out_valid",  32'(out_valid), 32'd1);
        chk("p1_out_instn",  out_instn,      32'h2008_0005);
        chk("p1_out_pc",     out_pc,         32'd0);
        chk("p1_out_nextpc", out_nextpc,     32'd4);
        chk("p1_count",      32'(count),     32'd1);

        // Fill, then hold a refused push
        drive(1'b1, 32'd4);
        step();
        chk("full_count",    32'(count),    32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_count",  32'(count), 32'd2);
            chk("hold_out_pc", out_pc,     32'd0);
            chk("hold_instn",  out_instn,  32'h2008_0005);
        end

        // Full with pop: push refused, then push+pop
        out_ready = 1'b1;
        step();
        chk("fp_count",  32'(count), 32'd1);
        chk("fp_out_pc", out_pc,     32'd4);
        step();
        chk("pp_count",     32'(count), 32'd1);
        chk("pp_out_pc",    out_pc,     32'd8);
        chk("pp_out_npc",   out_nextpc, 32'd12);
        chk("pp_out_instn", out_instn,  32'hA000_0008);

        // Idle cycle leaves state alone
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("idle_count",  32'(count), 32'd1);
        chk("idle_out_pc", out_pc,     32'd8);

        // Flush with push and pop pending
        drive(1'b1, 32'd12);
        step();
        chk("pre_fl_count", 32'(count), 32'd2);
        flush = 1'b1; out_ready = 1'b1; drive(1'b1, 32'd16);
        step();
        chk("fl_count",     32'(count),     32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_instn", out_instn,      32'd0);
        flush = 1'b0; out_ready = 1'b0; drive(1'b1, 32'd20);
        step();
        chk("post_fl_count",  32'(count), 32'd1);
        chk("post_fl_out_pc", out_pc,     32'd20);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("drain_count", 32'(count), 32'd0);

        // Streaming: 8 entries through with pointer wrap
        exp_idx = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(k < 8, 32'(k * 4));
            if (out_valid) begin
                chk("st_out_pc",    out_pc,     32'(exp_idx * 4));
                chk("st_out_npc",   out_nextpc, 32'(exp_idx * 4 + 4));
                chk("st_out_instn", out_instn,  32'hA000_0000 | 32'(exp_idx * 4));
                exp_idx++;
            end
            step();
        end
        chk("st_popped", 32'(exp_idx), 32'd8);
        chk("st_count",  32'(count),   32'd0);

        // Async reset between edges while full
        out_ready = 1'b0;
        drive(1'b1, 32'd100);
        step();
        drive(1'b1, 32'd104);
        step();
        chk("ar_pre_count", 32'(count), 32'd2);
        drive(1'b1, 32'd108);
        #2 reset = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_count",     32'(count),     32'd0);
        chk("ar_out_pc",    out_pc,         32'd0);
        // Push held across an edge in reset is not stored
        step();
        chk("ar_edge_count", 32'(count), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("rel_count", 32'(count), 32'd0);
        drive(1'b1, 32'h40);
        step();
        chk("rel_head_pc", out_pc,     32'h40);
        chk("rel_count1",  32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
